qpsk_bit_splitter: RTL and testbench

- Serial-to-dibit front end for the QPSK modulator.
- Accepts a serial bit stream over a valid/ready handshake and pairs bits into (I, Q).
- Holds each pair on Ichannel/Qchannel for exactly SPS clock cycles, one symbol period. The downstream carrier-sample selector reads these outputs and picks one of four signed carrier samples every clk.
- Flags underrun when the source starves the symbol timer.

---
 rtl/qpsk_bit_splitter.sv | 84 ++++++++
 tb/tb_qpsk_bit_splitter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/qpsk_bit_splitter.sv
// qpsk_bit_splitter: pairs a serial bit stream into (I,Q) symbols held for SPS clocks.
// Define QPSK_DIFF_EN to differentially encode each dibit through a 2-bit phase register.
module qpsk_bit_splitter #(
  parameter int SPS   = 16,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output logic Ichannel,
  output logic Qchannel,
  output logic sym_valid,
  output logic sym_strobe,
  output logic underrun
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] nbits_q, nbits_d, iq_new;
  logic b0_q, b0_d, b1_q, b1_d, i_q, i_d, q_q, q_d;
  logic sv_q, sv_d, strobe_q, strobe_d, ur_q, ur_d;
  logic boundary, load_now, xfer;
`ifdef QPSK_DIFF_EN
  logic [1:0] p_q, p_d, idx;
  // Gray-ordered phase index: 00->0, 01->1, 11->2, 10->3, and its inverse
  always_comb begin
    idx = {b0_q, b0_q ^ b1_q};
    p_d = load_now ? p_q + idx : p_q;
    iq_new = {p_d[1], p_d[1] ^ p_d[0]};
  end
  always_ff @(posedge clk)
    p_q <= rst ? 2'd0 : p_d;
`else
  assign iq_new = {b0_q, b1_q};
`endif
  assign bit_ready = (nbits_q < 2'd2) || load_now;
  always_comb begin
    boundary = (state_q == RUN) && (cnt_q == CNT_W'(SPS - 1));
    load_now = (nbits_q == 2'd2) && ((state_q == IDLE) || boundary);
    xfer = bit_valid && bit_ready;
    state_d = load_now ? RUN : boundary ? IDLE : state_q;
    cnt_d = ((state_q == IDLE) || boundary) ? '0 : cnt_q + 1'b1;
    sv_d = load_now ? 1'b1 : boundary ? 1'b0 : sv_q;
    strobe_d = load_now;
    ur_d = boundary && !load_now;
    {i_d, q_d} = load_now ? iq_new : {i_q, q_q};
    // a load frees the whole buffer, so a simultaneous transfer becomes the new b0
    nbits_d = load_now ? {1'b0, xfer} : nbits_q + {1'b0, xfer};
    b0_d = (xfer && (load_now || nbits_q == 2'd0)) ? bit_in : b0_q;
    b1_d = (xfer && !load_now && nbits_q == 2'd1) ? bit_in : b1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      nbits_q  <= 2'd0;
      b0_q     <= 1'b0;
      b1_q     <= 1'b0;
      i_q      <= 1'b0;
      q_q      <= 1'b0;
      sv_q     <= 1'b0;
      strobe_q <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nbits_q  <= nbits_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      i_q      <= i_d;
      q_q      <= q_d;
      sv_q     <= sv_d;
      strobe_q <= strobe_d;
      ur_q     <= ur_d;
    end
  end
  assign Ichannel   = i_q;
  assign Qchannel   = q_q;
  assign sym_valid  = sv_q;
  assign sym_strobe = strobe_q;
  assign underrun   = ur_q;
endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// tb_qpsk_bit_splitter: directed checks of pairing, timing, backpressure, underrun and reset (SPS=4).
module tb_qpsk_bit_splitter;
  logic clk = 1'b0;
  logic rst, bit_in, bit_valid;
  logic bit_ready, Ichannel, Qchannel, sym_valid, sym_strobe, underrun;
  int passed = 0, total = 0, fails = 0, cyc = 0;
  logic [1:0] syms[$];
  int stc[$];
  logic bad;

  qpsk_bit_splitter #(.SPS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .Ichannel(Ichannel), .Qchannel(Qchannel), .sym_valid(sym_valid),
    .sym_strobe(sym_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sym_strobe) begin
      syms.push_back({Ichannel, Qchannel});
      stc.push_back(cyc);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_iq(input string tag, input logic [1:0] plain, input logic [1:0] diff);
`ifdef QPSK_DIFF_EN
    chk(tag, {30'd0, Ichannel, Qchannel}, {30'd0, diff});
`else
    chk(tag, {30'd0, Ichannel, Qchannel}, {30'd0, plain});
`endif
  endtask

  task automatic drive(input logic v, input logic b);
    bit_valid = v;
    bit_in = b;
  endtask

  task automatic send(input logic b);
    int k;
    drive(1'b1, b);
    k = 0;
    while (!bit_ready && k < 20) begin
      tick();
      k++;
    end
    chk("send_ready_bound", {31'd0, k < 20}, 32'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_sv", {31'd0, sym_valid}, 0);
    chk("rst_strobe", {31'd0, sym_strobe}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_iq", {30'd0, Ichannel, Qchannel}, 0);
    chk("rst_ready", {31'd0, bit_ready}, 1);
    bad = 1'b0;
    repeat (20) begin
      tick();
      bad |= sym_valid | sym_strobe | underrun | Ichannel | Qchannel | !bit_ready;
    end
    chk("idle_quiet", {31'd0, bad}, 0);

    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b1); tick();
    chk("s2_not_yet_valid", {31'd0, sym_valid}, 0);
    chk("s2_ready_idle_full", {31'd0, bit_ready}, 1);
    drive(1'b1, 1'b1); tick();
    chk("s2_strobe1", {31'd0, sym_strobe}, 1);
    chk("s2_sv1", {31'd0, sym_valid}, 1);
    chk_iq("s2_sym1", 2'b01, 2'b01);
    drive(1'b1, 1'b1); tick();
    chk("s2_strobe_drop", {31'd0, sym_strobe}, 0);
    chk("s2_backpressure_a", {31'd0, bit_ready}, 0);
    drive(1'b1, 1'b1); tick();
    chk("s2_backpressure_b", {31'd0, bit_ready}, 0);
    tick();
    chk("s2_ready_boundary", {31'd0, bit_ready}, 1);
    tick();
    chk("s2_strobe2", {31'd0, sym_strobe}, 1);
    chk_iq("s2_sym2", 2'b11, 2'b10);
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick(); tick(); tick();
    chk("s2_strobe3", {31'd0, sym_strobe}, 1);
    chk_iq("s2_sym3", 2'b10, 2'b11);
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    chk("s2_no_strobe_mid", {31'd0, sym_strobe}, 0);
    chk("s2_sv_contiguous", {31'd0, sym_valid}, 1);
    tick(); tick();
    chk("s2_strobe4", {31'd0, sym_strobe}, 1);
    chk_iq("s2_sym4", 2'b00, 2'b11);
    tick(); tick(); tick();
    chk("s2_no_early_underrun", {31'd0, underrun}, 0);
    tick();
    chk("s2_underrun", {31'd0, underrun}, 1);
    chk("s2_underrun_sv", {31'd0, sym_valid}, 0);
    chk_iq("s2_underrun_hold", 2'b00, 2'b11);

    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b1); tick();
    drive(1'b1, 1'b1); tick();
    chk_iq("s3_sym1", 2'b01, 2'b01);
    drive(1'b1, 1'b1); tick();
    drive(1'b0, 1'b0); tick(); tick(); tick();
    chk_iq("s3_sym2", 2'b11, 2'b10);
    tick(); tick(); tick();
    chk("s3_underrun_not_yet", {31'd0, underrun}, 0);
    chk("s3_sv_before", {31'd0, sym_valid}, 1);
    tick();
    chk("s3_underrun", {31'd0, underrun}, 1);
    chk("s3_underrun_no_strobe", {31'd0, sym_strobe}, 0);
    chk("s3_sv_drop", {31'd0, sym_valid}, 0);
    chk_iq("s3_hold", 2'b11, 2'b10);
    drive(1'b1, 1'b1); tick();
    chk("s3_underrun_once", {31'd0, underrun}, 0);
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    chk("s3_restart_strobe", {31'd0, sym_strobe}, 1);
    chk("s3_restart_sv", {31'd0, sym_valid}, 1);
    chk_iq("s3_restart_sym", 2'b10, 2'b11);

    drive(1'b1, 1'b1); tick();
    drive(1'b0, 1'b0); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s4_sv", {31'd0, sym_valid}, 0);
    chk("s4_strobe", {31'd0, sym_strobe}, 0);
    chk("s4_underrun", {31'd0, underrun}, 0);
    chk("s4_iq", {30'd0, Ichannel, Qchannel}, 0);
    chk("s4_ready", {31'd0, bit_ready}, 1);
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b1); tick();
    chk("s4_no_stale_pair", {31'd0, sym_valid}, 0);
    drive(1'b0, 1'b0); tick();
    chk("s4_first_strobe", {31'd0, sym_strobe}, 1);
    chk_iq("s4_first_sym", 2'b01, 2'b01);

    rst = 1'b1; tick(); rst = 1'b0;
    syms.delete();
    stc.delete();
    send(1'b0); send(1'b1); send(1'b0); send(1'b1);
    send(1'b1); send(1'b1); send(1'b1); send(1'b0);
    drive(1'b0, 1'b0);
    repeat (8) tick();
    chk("s5_count", syms.size(), 4);
    if (syms.size() == 4) begin
`ifdef QPSK_DIFF_EN
      chk("s5_sym0", {30'd0, syms[0]}, 32'b01);
      chk("s5_sym1", {30'd0, syms[1]}, 32'b11);
      chk("s5_sym2", {30'd0, syms[2]}, 32'b00);
      chk("s5_sym3", {30'd0, syms[3]}, 32'b10);
`else
      chk("s5_sym0", {30'd0, syms[0]}, 32'b01);
      chk("s5_sym1", {30'd0, syms[1]}, 32'b01);
      chk("s5_sym2", {30'd0, syms[2]}, 32'b11);
      chk("s5_sym3", {30'd0, syms[3]}, 32'b10);
`endif
      for (int i = 0; i < 3; i++) chk("s5_spacing", stc[i+1] - stc[i], 4);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
